// File: rtl/nixie_pkg.sv
// Shared constants, FSM state encoding and helpers for the nixie chain driver.
package nixie_pkg;

  localparam int BITS_PER_TUBE = 12;
  localparam int DIGIT_BITS    = 10;
  localparam int CHIP_BITS     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_WAIT_LATCH,
    ST_LATCH
  } state_e;

  // Chain length rounded up to whole 32-bit driver chips.
  function automatic int chain_bits(input int n);
    return CHIP_BITS * ((BITS_PER_TUBE * n + CHIP_BITS - 1) / CHIP_BITS);
  endfunction

  // Digit 1..9 lights cathode offset d, digit 0 lights offset 10; blank or >9 lights nothing.
  function automatic logic [DIGIT_BITS-1:0] digit_onehot(input logic [3:0] d, input logic blank);
    logic [DIGIT_BITS-1:0] r;
    r = '0;
    if (!blank) begin
      if (d == 4'd0)       r[DIGIT_BITS-1] = 1'b1;
      else if (d <= 4'd9)  r[d - 4'd1]     = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nixie_frame_builder.sv
// Combinational mapping of BCD digits, blanking and points onto the chain frame.
module nixie_frame_builder
  import nixie_pkg::*;
#(
  parameter int NUM_TUBES  = 8,
  parameter int CHAIN_BITS = chain_bits(NUM_TUBES)
) (
  input  logic [4*NUM_TUBES-1:0] bcd_data_i,
  input  logic [NUM_TUBES-1:0]   bcd_blank_i,
  input  logic [2*NUM_TUBES-1:0] bcd_dp_i,
  output logic [CHAIN_BITS-1:0]  frame_o
);

  for (genvar t = 0; t < NUM_TUBES; t++) begin : g_tube
    assign frame_o[BITS_PER_TUBE*t] = bcd_dp_i[2*t];
    assign frame_o[BITS_PER_TUBE*t+1 +: DIGIT_BITS] =
      digit_onehot(bcd_data_i[4*t +: 4], bcd_blank_i[t]);
    assign frame_o[BITS_PER_TUBE*t+BITS_PER_TUBE-1] = bcd_dp_i[2*t+1];
  end

  // Unused chip outputs past the last tube are driven low.
  if (CHAIN_BITS > BITS_PER_TUBE*NUM_TUBES) begin : g_pad
    assign frame_o[CHAIN_BITS-1:BITS_PER_TUBE*NUM_TUBES] = '0;
  end

endmodule

// File: rtl/nixie_chain_driver.sv
// Serial driver for a daisy chain of 32-bit HV shift/latch chips feeding nixie tubes.
module nixie_chain_driver
  import nixie_pkg::*;
#(
  parameter int NUM_TUBES = 8,
  parameter int CLK_DIV   = 1,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [4*NUM_TUBES-1:0] bcd_data_i,
  input  logic [NUM_TUBES-1:0]   bcd_blank_i,
  input  logic [2*NUM_TUBES-1:0] bcd_dp_i,
  input  logic                   bcd_valid_i,
  output logic                   bcd_ready_o,
  input  logic                   pps_i,
  input  logic                   trig_sel_i,
  input  logic                   sw_trig_i,
  input  logic                   latch_on_pps_i,
  input  logic                   ovr_clr_i,
  output logic                   nixie_clk_o,
  output logic                   nixie_din_o,
  output logic                   nixie_le_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o
);

  localparam int CHAIN_BITS = chain_bits(NUM_TUBES);
  localparam int CNT_W      = $clog2(CHAIN_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CHAIN_BITS);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

  state_e                  state_q, state_d;
  logic [7:0]              div_q, div_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CHAIN_BITS-1:0]   sreg_q, sreg_d;
  logic [4*NUM_TUBES-1:0]  data_q, data_d;
  logic [NUM_TUBES-1:0]    blank_q, blank_d;
  logic [2*NUM_TUBES-1:0]  dp_q, dp_d;
  logic                    pending_q, pending_d;
  logic                    lop_q, lop_d;
  logic                    ovr_q, ovr_d;
  logic [2:0]              pps_q;
  logic                    ready_q, ready_d;
  logic                    le_q, le_d;
  logic                    clk_q, clk_d;
  logic                    din_q, din_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [CHAIN_BITS-1:0]   frame;
  logic                    pps_rise, pps_fall, trig, accept, div_last;

  nixie_frame_builder #(
    .NUM_TUBES  (NUM_TUBES),
    .CHAIN_BITS (CHAIN_BITS)
  ) u_frame (
    .bcd_data_i  (data_q),
    .bcd_blank_i (blank_q),
    .bcd_dp_i    (dp_q),
    .frame_o     (frame)
  );

  // pps_q[1:0] is the synchroniser, pps_q[2] the previous synchronised level.
  assign pps_rise = pps_q[1] & ~pps_q[2];
  assign pps_fall = ~pps_q[1] & pps_q[2];
  assign trig     = trig_sel_i ? sw_trig_i : pps_fall;
  assign accept   = bcd_valid_i & ready_q;
  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    data_d    = data_q;
    blank_d   = blank_q;
    dp_d      = dp_q;
    lop_d     = lop_q;
    ovr_d     = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d   = ST_SETUP;
          sreg_d    = frame;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end
      ST_SETUP:  if (div_last) state_d = ST_CLK_HI;
      ST_CLK_HI: begin
        if (div_last) begin
          state_d = ST_CLK_LO;
          sreg_d  = sreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_CLK_LO: begin
        if (div_last) state_d = (cnt_q == CNT_END) ? ST_WAIT_LATCH : ST_CLK_HI;
      end
      ST_WAIT_LATCH: if (!lop_q || pps_rise) state_d = ST_LATCH;
      ST_LATCH:      if (div_last) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // New data lands in the shadow even when a trigger consumes the old one.
    if (accept) begin
      data_d    = bcd_data_i;
      blank_d   = bcd_blank_i;
      dp_d      = bcd_dp_i;
      pending_d = 1'b1;
    end

    if (ovr_clr_i) ovr_d = 1'b0;
    if (trig && state_q != ST_IDLE) ovr_d = 1'b1;

    if (state_d == ST_WAIT_LATCH && state_q != ST_WAIT_LATCH) lop_d = latch_on_pps_i;

    div_d   = (state_d != state_q) ? 8'd0 : div_q + 8'd1;
    le_d    = (state_d == ST_IDLE) || (state_d == ST_LATCH);
    clk_d   = (state_d == ST_CLK_HI);
    din_d   = (state_d == ST_IDLE) ? 1'b0 : sreg_d[0];
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_LATCH) && (div_d == DIV_LAST);
    ready_d = OVERWRITE ? 1'b1 : !pending_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      sreg_q    <= '0;
      data_q    <= '0;
      blank_q   <= '1;
      dp_q      <= '0;
      pending_q <= 1'b0;
      lop_q     <= 1'b0;
      ovr_q     <= 1'b0;
      pps_q     <= '0;
      ready_q   <= 1'b1;
      le_q      <= 1'b1;
      clk_q     <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      blank_q   <= blank_d;
      dp_q      <= dp_d;
      pending_q <= pending_d;
      lop_q     <= lop_d;
      ovr_q     <= ovr_d;
      pps_q     <= {pps_q[1:0], pps_i};
      ready_q   <= ready_d;
      le_q      <= le_d;
      clk_q     <= clk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bcd_ready_o = ready_q;
  assign nixie_clk_o = clk_q;
  assign nixie_din_o = din_q;
  assign nixie_le_o  = le_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_nixie_chain_driver.sv
// Directed bench: 8-tube/full-rate/overwrite instance A and 6-tube/div-3/no-overwrite instance B.
module tb_nixie_chain_driver;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  blank;
    logic [15:0] dp;
    logic [95:0] frame;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pps, lop, ovr_clr;

  logic [31:0] a_data;  logic [7:0] a_blank; logic [15:0] a_dp;
  logic a_valid, a_ready, a_tsel, a_sw, a_nclk, a_din, a_le, a_busy, a_done, a_ov;
  logic [23:0] b_data;  logic [5:0] b_blank; logic [11:0] b_dp;
  logic b_valid, b_ready, b_tsel, b_sw, b_nclk, b_din, b_le, b_busy, b_done, b_ov;

  nixie_chain_driver #(.NUM_TUBES(8), .CLK_DIV(1), .OVERWRITE(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .bcd_data_i(a_data), .bcd_blank_i(a_blank), .bcd_dp_i(a_dp),
    .bcd_valid_i(a_valid), .bcd_ready_o(a_ready), .pps_i(pps), .trig_sel_i(a_tsel),
    .sw_trig_i(a_sw), .latch_on_pps_i(lop), .ovr_clr_i(ovr_clr), .nixie_clk_o(a_nclk),
    .nixie_din_o(a_din), .nixie_le_o(a_le), .busy_o(a_busy), .done_o(a_done), .overrun_o(a_ov));

  nixie_chain_driver #(.NUM_TUBES(6), .CLK_DIV(3), .OVERWRITE(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .bcd_data_i(b_data), .bcd_blank_i(b_blank), .bcd_dp_i(b_dp),
    .bcd_valid_i(b_valid), .bcd_ready_o(b_ready), .pps_i(pps), .trig_sel_i(b_tsel),
    .sw_trig_i(b_sw), .latch_on_pps_i(1'b0), .ovr_clr_i(1'b0), .nixie_clk_o(b_nclk),
    .nixie_din_o(b_din), .nixie_le_o(b_le), .busy_o(b_busy), .done_o(b_done), .overrun_o(b_ov));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain-side monitors: capture DIN on every serial rising edge, log done pulses.
  logic [127:0] a_cap = '0, b_cap = '0;
  int a_nrise = 0, b_nrise = 0, a_dcnt = 0, b_dcnt = 0, a_dcyc = 0, b_dcyc = 0;
  int b_hirun = 0, b_lorun = 0, b_perr = 0;
  logic a_pclk = 1'b0, b_pclk = 1'b0;

  always @(negedge clk) begin
    if (a_nclk === 1'b1 && !a_pclk && a_nrise < 128) begin a_cap[a_nrise] = a_din; a_nrise++; end
    a_pclk = (a_nclk === 1'b1);
    if (a_done === 1'b1) begin a_dcnt++; a_dcyc = cyc; end

    if (b_nclk === 1'b1) b_hirun++;
    else if (b_le === 1'b0) b_lorun++;
    if (b_nclk === 1'b1 && !b_pclk) begin
      if (b_lorun != 3) b_perr++;
      b_lorun = 0;
      if (b_nrise < 128) begin b_cap[b_nrise] = b_din; b_nrise++; end
    end
    if (b_nclk === 1'b0 && b_pclk) begin
      if (b_hirun != 3) b_perr++;
      b_hirun = 0;
    end
    b_pclk = (b_nclk === 1'b1);
    if (b_done === 1'b1) begin b_dcnt++; b_dcyc = cyc; end
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_a();
    a_cap = '0; a_nrise = 0;
  endtask

  task automatic clr_b();
    b_cap = '0; b_nrise = 0; b_hirun = 0; b_lorun = 0; b_perr = 0;
  endtask

  task automatic wait_a(input int target, input int budget, input string nm);
    int n = 0;
    while (a_dcnt < target && n < budget) begin @(negedge clk); n++; end
    chk(nm, 128'(a_dcnt >= target), 128'd1);
  endtask

  task automatic wait_b(input int target, input int budget, input string nm);
    int n = 0;
    while (b_dcnt < target && n < budget) begin @(negedge clk); n++; end
    chk(nm, 128'(b_dcnt >= target), 128'd1);
  endtask

  task automatic load_a(input vec_t v);
    tick(); a_data = v.data; a_blank = v.blank; a_dp = v.dp; a_valid = 1'b1;
    @(negedge clk); chk("a ready", 128'(a_ready), 128'd1);
    tick(); a_valid = 1'b0;
  endtask

  task automatic trig_a(input bit use_pps, output int tc);
    tick();
    if (use_pps) pps = 1'b0; else a_sw = 1'b1;
    @(negedge clk); tc = cyc;
    tick(); a_sw = 1'b0;
  endtask

  task automatic trig_b(output int tc);
    tick(); b_sw = 1'b1;
    @(negedge clk); tc = cyc;
    tick(); b_sw = 1'b0;
  endtask

  vec_t vecs[4];
  logic [95:0] b_fa, b_fb;
  int tc, tgt;

  initial begin
    vecs[0] = '{32'h1234_5670, 8'h00, 16'h0000, 96'h002_004_008_010_020_040_080_400};
    vecs[1] = '{32'h9876_5B21, 8'h20, 16'h0C00, 96'h200_100_801_040_020_000_004_002};
    vecs[2] = '{32'h0000_00F0, 8'h81, 16'h8001, 96'h800_400_400_400_400_400_000_001};
    vecs[3] = '{32'h9999_9999, 8'h00, 16'hAAAA, 96'hA00_A00_A00_A00_A00_A00_A00_A00};
    b_fa = 96'h000000_040_020_010_008_004_002;
    b_fb = 96'h000000_000_400_400_200_100_881;

    rst_n = 1'b0; pps = 1'b1; lop = 1'b0; ovr_clr = 1'b0;
    a_data = '0; a_blank = '0; a_dp = '0; a_valid = 1'b0; a_tsel = 1'b0; a_sw = 1'b0;
    b_data = '0; b_blank = '0; b_dp = '0; b_valid = 1'b0; b_tsel = 1'b1; b_sw = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("a reset {le,clk,din,busy,done,ovr,ready}",
        128'({a_le, a_nclk, a_din, a_busy, a_done, a_ov, a_ready}), 128'b1000001);
    chk("b reset {le,clk,din,busy,done,ovr,ready}",
        128'({b_le, b_nclk, b_din, b_busy, b_done, b_ov, b_ready}), 128'b1000001);

    // Frame vectors on A: first via PPS falling edge, rest via software strobe.
    for (int i = 0; i < 4; i++) begin
      load_a(vecs[i]);
      clr_a(); tgt = a_dcnt + 1;
      a_tsel = (i != 0);
      trig_a(i == 0, tc);
      wait_a(tgt, 400, $sformatf("a v%0d done timeout", i));
      chk($sformatf("a v%0d frame", i), 128'(a_cap[95:0]), 128'(vecs[i].frame));
      chk($sformatf("a v%0d rises", i), 128'(a_nrise), 128'd96);
      chk($sformatf("a v%0d latency", i), 128'(a_dcyc - tc), (i == 0) ? 128'd197 : 128'd195);
      repeat (2) @(negedge clk);
      chk($sformatf("a v%0d idle {busy,le,clk}", i), 128'({a_busy, a_le, a_nclk}), 128'b010);
    end

    // Overrun while shifting; clear, then clear colliding with a new overrun.
    clr_a(); tgt = a_dcnt + 1;
    trig_a(1'b0, tc);
    repeat (30) tick();
    a_sw = 1'b1; tick(); a_sw = 1'b0;
    @(negedge clk); chk("a overrun set", 128'(a_ov), 128'd1);
    tick(); ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    @(negedge clk); chk("a overrun cleared", 128'(a_ov), 128'd0);
    tick(); ovr_clr = 1'b1; a_sw = 1'b1; tick(); ovr_clr = 1'b0; a_sw = 1'b0;
    @(negedge clk); chk("a overrun beats clear", 128'(a_ov), 128'd1);
    wait_a(tgt, 400, "a ovr done timeout");
    chk("a ovr frame intact", 128'(a_cap[95:0]), 128'(vecs[3].frame));
    chk("a ovr latency", 128'(a_dcyc - tc), 128'd195);
    tick(); ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    @(negedge clk); chk("a overrun cleared idle", 128'(a_ov), 128'd0);

    // Latch held until the PPS rising edge arrives much later.
    lop = 1'b1;
    clr_a(); tgt = a_dcnt + 1;
    trig_a(1'b0, tc);
    repeat (250) @(negedge clk);
    chk("a lop rises", 128'(a_nrise), 128'd96);
    chk("a lop waiting {busy,le}", 128'({a_busy, a_le}), 128'b10);
    repeat (10000) @(negedge clk);
    chk("a lop no early done", 128'(a_dcnt), 128'(tgt - 1));
    tick(); pps = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk($sformatf("a lop le low +%0d", k), 128'(a_le), 128'd0);
    end
    @(negedge clk); chk("a lop {le,done} +3", 128'({a_le, a_done}), 128'b11);
    @(negedge clk); chk("a lop {busy,le} +4", 128'({a_busy, a_le}), 128'b01);
    chk("a lop frame", 128'(a_cap[95:0]), 128'(vecs[3].frame));
    lop = 1'b0;

    // B: ready held low while pending; B accepted right after the trigger; A is shifted.
    tick(); b_data = 24'h654321; b_blank = '0; b_dp = '0; b_valid = 1'b1;
    @(negedge clk); chk("b ready empty", 128'(b_ready), 128'd1);
    tick(); b_data = 24'h000987; b_blank = 6'b100000; b_dp = 12'h003;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk($sformatf("b ready pending %0d", k), 128'(b_ready), 128'd0);
      tick();
    end
    clr_b(); tgt = b_dcnt + 1;
    b_sw = 1'b1;
    @(negedge clk); tc = cyc;
    tick(); b_sw = 1'b0;
    @(negedge clk); chk("b ready after trig", 128'(b_ready), 128'd1);
    tick(); b_valid = 1'b0;
    @(negedge clk); chk("b pending again {ready,busy}", 128'({b_ready, b_busy}), 128'b01);
    wait_b(tgt, 700, "b frame A done timeout");
    chk("b frame A", 128'(b_cap[95:0]), 128'(b_fa));
    chk("b frame A rises", 128'(b_nrise), 128'd96);
    chk("b frame A latency", 128'(b_dcyc - tc), 128'd583);
    chk("b frame A phase errors", 128'(b_perr), 128'd0);

    clr_b(); tgt = b_dcnt + 1;
    trig_b(tc);
    wait_b(tgt, 700, "b frame B done timeout");
    chk("b frame B", 128'(b_cap[95:0]), 128'(b_fb));
    chk("b frame B latency", 128'(b_dcyc - tc), 128'd583);
    chk("b frame B phase errors", 128'(b_perr), 128'd0);
    chk("b ready after drain", 128'(b_ready), 128'd1);

    // Reset mid-shift on A (with data pending on B): nothing latched afterwards.
    tick(); b_valid = 1'b1; tick(); b_valid = 1'b0;
    @(negedge clk); chk("b ready pending pre-reset", 128'(b_ready), 128'd0);
    clr_a(); tgt = a_dcnt + 1;
    trig_a(1'b0, tc);
    repeat (20) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("a mid reset {le,clk,din,busy,done,ovr}",
        128'({a_le, a_nclk, a_din, a_busy, a_done, a_ov}), 128'b100000);
    chk("b ready after reset", 128'(b_ready), 128'd1);
    repeat (400) @(negedge clk);
    chk("a no latch after reset", 128'(a_dcnt), 128'(tgt - 1));
    chk("a le after reset", 128'({a_le, a_busy}), 128'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nixie_chain_driver.md
# nixie_chain_driver

Parametrised serial driver for a daisy-chain of 32-bit high-voltage shift-register/latch chips feeding N nixie tubes. Accepts packed BCD digits, blanking masks and decimal-point bits through a valid/ready handshake into a shadow register. It builds a one-hot tube frame and shifts it out on a programmable-rate serial clock when a trigger arrives (PPS falling edge or software strobe). It latches the chain either immediately or on the next PPS rising edge. It sits between the timekeeping/BCD logic and the tube driver pins, and replaces the fixed 8-tube, full-speed driver.

## Interface
- NUM_TUBES, 8, number of tubes (1..16)
- CLK_DIV, 1, `clk` cycles per serial-clock phase (1..255)
- OVERWRITE, 1, 1: new data always accepted, replacing a pending frame; 0: `bcd_ready` low while a frame is pending
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- bcd_data  in  4*NUM_TUBES  digit per tube; tube 0 in bits [3:0]
- bcd_blank  in  NUM_TUBES  1 = tube blank
- bcd_dp  in  2*NUM_TUBES  tube t: [2t] = right point, [2t+1] = left point
- bcd_valid  in  1  data offered
- bcd_ready  out  1  data accepted when valid & ready
- pps  in  1  asynchronous PPS input
- trig_sel  in  1  0: trigger on PPS falling edge; 1: trigger on `sw_trig`
- sw_trig  in  1  one-cycle software trigger
- latch_on_pps  in  1  1: hold LE low until the PPS rising edge; 0: latch immediately
- ovr_clr  in  1  clears `overrun`
- nixie_clk  out  1  serial clock
- nixie_din  out  1  serial data
- nixie_le  out  1  latch enable (high = transparent/latched, as chip)
- busy  out  1  shift/latch sequence in progress
- done  out  1  one-cycle pulse when LE returns high
- overrun  out  1  sticky; a trigger arrived while `busy`

## Operation
- Frame: tube t occupies bits [12t+11:12t].
  - bit 12t = right point; bit 12t+11 = left point.
  - Bits 12t+1..12t+10 form a one-hot digit: value 1..9 sets bit offset d; value 0 sets offset 10.
  - Blank, or value >9, gives all ten digit bits zero. Points are unaffected by blanking.
- Chain length CHAIN_BITS = 32*ceil(12*NUM_TUBES/32). Pad bits are 0.
- Frame bit 0 is shifted first and bit CHAIN_BITS-1 last.
- Shadow register: written on valid & ready; sets `pending`.
  - `bcd_ready` = 1 when OVERWRITE=1; otherwise `bcd_ready` = !pending.
  - Reset value of the shadow is all-blank with no points.
- PPS path: 2-flop synchroniser plus edge register. A falling or rising edge is seen 3 cycles after the pin edge.
- Trigger is accepted in IDLE only. It loads the shift register from the frame built from the shadow, clears `pending`, and goes to SETUP.
  - Triggers while `busy` are ignored and set `overrun`.
  - If `ovr_clr` and a new overrun occur in the same cycle, the overrun wins.
- States:
  - IDLE: LE=1, CLK=0.
  - SETUP: LE=0, CLK=0, DIN=bit 0. Lasts CLK_DIV cycles.
  - CLK_HI: CLK=1 for CLK_DIV cycles.
  - CLK_LO: CLK=0 for CLK_DIV cycles. Shift and increment the counter on entry. Go back to CLK_HI until CHAIN_BITS rising edges are done, then go to WAIT_LATCH.
  - WAIT_LATCH: LE=0. Leave at once if latch_on_pps=0 (sampled on entry); otherwise leave on the synchronised PPS rising edge.
  - LATCH: LE=1 for CLK_DIV cycles. `done` pulses on the last cycle. Then IDLE.
- Simultaneous handshake and trigger in IDLE: the frame comes from the old shadow. New data goes to the shadow and stays pending.

## Timing
- Reset values: nixie_le=1, nixie_clk=0, nixie_din=0, busy=0, done=0, overrun=0, bcd_ready=1, pending=0, state IDLE.
- Reset asserted mid-sequence: all outputs are at reset values the next cycle. The partial frame is discarded and the chain is not latched.
- All outputs are registered. `busy` is high from SETUP through LATCH inclusive.
- DIN changes only on CLK falling edges or in SETUP, so it is stable CLK_DIV cycles before each rising edge.
- Sequence length with latch_on_pps=0: (2*CHAIN_BITS+2)*CLK_DIV + 1 cycles, from the trigger cycle to `done`.
- Widths: bit counter is $clog2(CHAIN_BITS+1) bits; divider counter is 8 bits.

## Structure
- `nixie_pkg` holds:
  - constants BITS_PER_TUBE=12, DIGIT_BITS=10, CHIP_BITS=32;
  - the state enum;
  - function `chain_bits(n)`.
- Sub-module `nixie_frame_builder`: combinational BCD/blank/dp to CHAIN_BITS frame, one instance per driver.

## Test plan
- NUM_TUBES=8, CLK_DIV=1, trig_sel=0, latch_on_pps=0, bcd_data=0x12345670, no blank, no dp, PPS falling -> 96 CLK rising edges. Tube 0 slot = 0x400 (digit 0, offset 10). LE high for 1 cycle. `done` 195 cycles after trigger detection.
- NUM_TUBES=6, CLK_DIV=3 -> CHAIN_BITS=96, last 24 bits shifted are 0, each CLK phase is 3 cycles.
- latch_on_pps=1, PPS rising 10 000 cycles later -> LE stays low until 3 cycles after the pin edge, then high for CLK_DIV cycles.
- Digit 0xB on tube 2 and bcd_blank[5]=1 with bcd_dp[11:10]=2'b11 -> tube 2 digit bits all 0. Tube 5 sends only bits 60 and 71 set.
- OVERWRITE=0: accept frame A, hold valid with frame B -> ready low until the trigger. B is accepted the cycle after the trigger, and the frame shifted is A.
- sw_trig during shifting -> overrun=1, sequence uninterrupted. ovr_clr -> overrun=0. Reset mid-shift -> LE=1, CLK=0, busy=0 the next cycle.
